// File: rtl/lc3_decode.sv
// LC-3 decode stage: registers IR/NPC and the execute, writeback and memory control words.
// Optional LC3_DECODE_ILLEGAL_FLAG_EN adds a registered illegal_instr flag for unsupported opcodes.
module lc3_decode (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_decode,
    input  logic [15:0] npc_in,
    input  logic [15:0] instr_dout,
    input  logic [2:0]  psr,
    output logic [15:0] IR,
    output logic [15:0] npc_out,
    output logic [5:0]  E_Control,
    output logic [1:0]  W_Control,
    output logic        Mem_Control,
`ifdef LC3_DECODE_ILLEGAL_FLAG_EN
    output logic        illegal_instr,
`endif
    output logic        decode_valid
);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_RTI = 4'b1000;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_RES = 4'b1101;
    localparam logic [3:0] OP_LEA = 4'b1110;
    localparam logic [3:0] OP_TRP = 4'b1111;

    logic [3:0] opcode;
    logic [1:0] alu_control;
    logic [1:0] pcselect1;
    logic       pcselect2;
    logic       op2select;
    logic [1:0] w_next;
    logic       mem_next;
    logic       illegal_next;

    // psr rides along on the bus but decode never looks at it.
    logic unused_psr;
    assign unused_psr = ^psr;

    assign opcode = instr_dout[15:12];

    always_comb begin
        alu_control  = 2'b00;
        pcselect1    = 2'b00;
        pcselect2    = 1'b0;
        op2select    = 1'b0;
        w_next       = 2'b00;
        mem_next     = 1'b0;
        illegal_next = 1'b0;
        case (opcode)
            OP_ADD: op2select = ~instr_dout[5];
            OP_AND: begin
                alu_control = 2'b01;
                op2select   = ~instr_dout[5];
            end
            OP_NOT: alu_control = 2'b10;
            OP_BR, OP_LD, OP_ST, OP_LEA, OP_LDI, OP_STI: begin
                pcselect1 = 2'b01;
                pcselect2 = 1'b1;
                if (opcode == OP_LD || opcode == OP_LDI) w_next = 2'b01;
                if (opcode == OP_LEA)                    w_next = 2'b10;
                mem_next = (opcode == OP_LDI) || (opcode == OP_STI);
            end
            OP_LDR, OP_STR: begin
                pcselect1 = 2'b10;
                if (opcode == OP_LDR) w_next = 2'b01;
            end
            OP_JMP: pcselect1 = 2'b11;
            OP_JSR, OP_RTI, OP_RES, OP_TRP: illegal_next = 1'b1;
            default: illegal_next = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            IR           <= 16'h0000;
            npc_out      <= 16'h0000;
            E_Control    <= 6'h00;
            W_Control    <= 2'b00;
            Mem_Control  <= 1'b0;
            decode_valid <= 1'b0;
        end else begin
            decode_valid <= enable_decode;
            if (enable_decode) begin
                IR          <= instr_dout;
                npc_out     <= npc_in;
                E_Control   <= {alu_control, pcselect1, pcselect2, op2select};
                W_Control   <= w_next;
                Mem_Control <= mem_next;
            end
        end
    end

`ifdef LC3_DECODE_ILLEGAL_FLAG_EN
    always_ff @(posedge clock) begin
        if (reset)              illegal_instr <= 1'b0;
        else if (enable_decode) illegal_instr <= illegal_next;
    end
`else
    logic unused_illegal;
    assign unused_illegal = illegal_next;
`endif

endmodule
